// File: rtl/kyber_axi_host_master.sv
// Single-outstanding AXI4 INCR burst master for the Kyber accelerator slave port.
// One host command in, one AXI burst out, one done pulse with the burst response.
module kyber_axi_host_master #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 8
) (
    input  logic                m_axi_aclk,
    input  logic                m_axi_aresetn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,

    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,

    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                rd_last,
    input  logic                rd_ready,

    output logic                done,
    output logic [1:0]          resp,
    output logic                busy,

    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [LEN_W-1:0]    m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic [3:0]          m_axi_awcache,
    output logic                m_axi_awlock,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,

    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,

    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,

    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [LEN_W-1:0]    m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic [3:0]          m_axi_arcache,
    output logic                m_axi_arlock,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,

    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic [1:0]         resp_q;
    logic               awvalid_q;
    logic               arvalid_q;
    logic               bready_q;

    logic [LEN_W:0]     end_word;
    logic               bad_cmd;
    logic               last_beat;
    logic [1:0]         rd_acc;

    // Misaligned starts and bursts running past the 4 KB page end are refused locally.
    assign end_word  = (LEN_W+1)'(cmd_addr[11:4]) + (LEN_W+1)'(cmd_len);
    assign bad_cmd   = (cmd_addr[3:0] != 4'd0) || (end_word > (LEN_W+1)'(255));
    assign last_beat = (cnt == len_q);

    // SLVERR/DECERR dominate; rlast out of place with the beat count is a slave error.
    always_comb begin
        rd_acc = (m_axi_rresp > resp_q) ? m_axi_rresp : resp_q;
        if ((last_beat != m_axi_rlast) && (rd_acc < 2'b10))
            rd_acc = 2'b10;
    end

    always_ff @(posedge m_axi_aclk) begin
        if (!m_axi_aresetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    if (bad_cmd) begin
                        resp_q <= 2'b10;
                        state  <= DONE;
                    end else begin
                        addr_q <= cmd_addr;
                        len_q  <= cmd_len;
                        cnt    <= '0;
                        resp_q <= 2'b00;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            state     <= AW;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= AR;
                        end
                    end
                end
                AW: if (m_axi_awready) begin
                    awvalid_q <= 1'b0;
                    state     <= W;
                end
                W: if (m_axi_wvalid && m_axi_wready) begin
                    if (last_beat) begin
                        bready_q <= 1'b1;
                        state    <= B;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                B: if (m_axi_bvalid) begin
                    bready_q <= 1'b0;
                    resp_q   <= m_axi_bresp;
                    state    <= DONE;
                end
                AR: if (m_axi_arready) begin
                    arvalid_q <= 1'b0;
                    state     <= R;
                end
                R: if (m_axi_rvalid && m_axi_rready) begin
                    resp_q <= rd_acc;
                    if (last_beat) state <= DONE;
                    else           cnt   <= cnt + 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign resp      = resp_q;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'b100;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'b100;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;

    // Data channels are straight pass-throughs, opened only in their own phase.
    assign m_axi_wdata  = (state == W) ? wr_data : '0;
    assign m_axi_wstrb  = '1;
    assign m_axi_wvalid = (state == W) && wr_valid;
    assign m_axi_wlast  = (state == W) && last_beat;
    assign wr_ready     = (state == W) && m_axi_wready;
    assign m_axi_bready = bready_q;

    assign rd_data      = (state == R) ? m_axi_rdata : '0;
    assign rd_valid     = (state == R) && m_axi_rvalid;
    assign rd_last      = (state == R) && last_beat;
    assign m_axi_rready = (state == R) && rd_ready;
endmodule

// File: tb/tb_kyber_axi_host_master.sv
// Directed bench: table of host commands run against a cycle-stepped AXI slave model.
module tb_kyber_axi_host_master;
    logic         clk = 1'b0;
    logic         aresetn;
    logic         cmd_valid, cmd_ready, cmd_write;
    logic [16:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic [127:0] wr_data;
    logic         wr_valid, wr_ready;
    logic [127:0] rd_data;
    logic         rd_valid, rd_last, rd_ready;
    logic         done, busy;
    logic [1:0]   resp;
    logic [16:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, awprot, arsize, arprot;
    logic [1:0]   awburst, arburst;
    logic [3:0]   awcache, arcache;
    logic         awlock, awvalid, awready, arlock, arvalid, arready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    kyber_axi_host_master dut (
        .m_axi_aclk(clk), .m_axi_aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done(done), .resp(resp), .busy(busy),
        .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awcache(awcache), .m_axi_awlock(awlock),
        .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arcache(arcache), .m_axi_arlock(arlock),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    typedef struct {
        logic         wr;
        logic [16:0]  addr;
        logic [7:0]   len;
        logic [127:0] dbase;      // beat b carries dbase + b
        int           aw_dly;     // AxREADY withheld for this many AxVALID cycles
        int           wgap;       // wready low every wgap-th cycle (0 = always ready)
        bit           wtog;       // wr_valid toggles 1/0
        int           rstall;     // rd_ready low this many cycles on beat 0
        int           err_beat;   // beat returning rresp=SLVERR (-1 none)
        int           early_last; // extra rlast on this beat (-1 none)
        int           rst_beat;   // pulse reset while this W beat is pending (-1 none)
        logic [1:0]   exp_resp;
        bit           exp_err;    // rejected locally, no AXI traffic
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int cyc = 0, wbeat = 0, rbeat = 0, awcyc = 0, arcyc = 0, stall = 0, done_cyc = -1;
        bit aw_ok = 0, ar_ok = 0, axi_seen = 0, hit_rst = 0;
        logic [1:0] got_resp = 2'b00;
        while (cyc < 1000) begin
            @(negedge clk);
            cmd_valid = (cyc == 0);
            cmd_write = v.wr;
            cmd_addr  = v.addr;
            cmd_len   = v.len;
            aresetn   = !(v.rst_beat >= 0 && aw_ok && wbeat == v.rst_beat);
            awready   = awvalid && (awcyc >= v.aw_dly);
            arready   = arvalid && (arcyc >= v.aw_dly);
            wready    = !(v.wgap > 0 && (cyc % v.wgap) == v.wgap - 1);
            wr_valid  = v.wtog ? (cyc % 2 == 0) : 1'b1;
            wr_data   = v.dbase + 128'(wbeat);
            bvalid    = bready;
            bresp     = 2'b00;
            rvalid    = ar_ok && (rbeat <= int'(v.len));
            rdata     = v.dbase + 128'(rbeat);
            rresp     = (rbeat == v.err_beat) ? 2'b10 : 2'b00;
            rlast     = (rbeat == int'(v.len)) || (rbeat == v.early_last);
            rd_ready  = !(rbeat == 0 && stall < v.rstall);
            #1;
            if (cyc == 0) check({tag, " cmd_ready idle"}, cmd_ready, 1);
            if (cyc == 1 && !v.exp_err) check({tag, " busy"}, busy, 1);
            if (awvalid || arvalid) axi_seen = 1;
            if (awvalid && arvalid) check({tag, " aw/ar overlap"}, 1, 0);
            if (awvalid) begin
                awcyc++;
                check({tag, " awaddr"}, awaddr, v.addr);
                check({tag, " awlen"}, awlen, v.len);
                if (awready) begin
                    aw_ok = 1;
                    check({tag, " aw hold cycles"}, awcyc, v.aw_dly + 1);
                    check({tag, " aw consts"}, {awsize, awburst, awcache, awlock, awprot, wstrb},
                          {3'b100, 2'b01, 4'b0011, 1'b0, 3'b000, 16'hFFFF});
                end
            end
            if (arvalid) begin
                arcyc++;
                check({tag, " araddr"}, araddr, v.addr);
                check({tag, " arlen"}, arlen, v.len);
                if (arready) begin
                    ar_ok = 1;
                    check({tag, " ar consts"}, {arsize, arburst, arcache, arlock, arprot},
                          {3'b100, 2'b01, 4'b0011, 1'b0, 3'b000});
                end
            end
            if (wvalid && wready) begin
                check({tag, " w after aw"}, aw_ok, 1);
                check({tag, " wr_ready"}, wr_ready, 1);
                check($sformatf("%s wdata b%0d", tag, wbeat), wdata, v.dbase + 128'(wbeat));
                check($sformatf("%s wlast b%0d", tag, wbeat), wlast, wbeat == int'(v.len));
                wbeat++;
            end
            if (rvalid) begin
                check({tag, " rd_valid"}, rd_valid, 1);
                check({tag, " rready"}, rready, rd_ready);
                if (!rd_ready) stall++;
                else begin
                    check($sformatf("%s rd_data b%0d", tag, rbeat), rd_data, v.dbase + 128'(rbeat));
                    check($sformatf("%s rd_last b%0d", tag, rbeat), rd_last, rbeat == int'(v.len));
                    rbeat++;
                end
            end
            if (!aresetn) begin
                hit_rst = 1;
                break;
            end
            if (done) begin
                done_cyc = cyc;
                got_resp = resp;
                check({tag, " cmd_ready in done"}, cmd_ready, 0);
                break;
            end
            cyc++;
        end
        cmd_valid = 0;
        if (hit_rst) begin
            @(negedge clk);
            aresetn  = 1;
            wr_valid = 0;
            #1;
            check({tag, " post-reset valids"}, {awvalid, arvalid, wvalid, bready, rready}, 0);
            check({tag, " post-reset idle"}, {cmd_ready, busy, done, resp}, {1'b1, 1'b0, 1'b0, 2'b00});
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                check({tag, " no done after reset"}, done, 0);
            end
            return;
        end
        check({tag, " done seen"}, done_cyc >= 0, 1);
        check({tag, " resp"}, got_resp, v.exp_resp);
        if (v.exp_err) begin
            check({tag, " no axi traffic"}, axi_seen, 0);
            check({tag, " done latency"}, done_cyc <= 2, 1);
        end else if (v.wr) begin
            check({tag, " w beats"}, wbeat, int'(v.len) + 1);
        end else begin
            check({tag, " r beats"}, rbeat, int'(v.len) + 1);
        end
        @(negedge clk);
        #1;
        check({tag, " done one cycle"}, done, 0);
        check({tag, " idle after"}, {busy, cmd_ready}, 2'b01);
    endtask

    vec_t vt [7];
    vec_t vr;

    initial begin
        vt[0] = '{1'b1, 17'h00020, 8'd0,  128'h3, 3, 0, 1'b0, 0, -1, -1, -1, 2'b00, 1'b0};
        vt[1] = '{1'b1, 17'h10000, 8'd49, 128'hA5A5_0000_0000_0000_0000_0000_0000_1000, 0, 3, 1'b1, 0, -1, -1, -1, 2'b00, 1'b0};
        vt[2] = '{1'b0, 17'h10E40, 8'd1,  128'h1111_2222_3333_4444_5555_6666_7777_0000, 1, 0, 1'b0, 5, -1, -1, -1, 2'b00, 1'b0};
        vt[3] = '{1'b0, 17'h10100, 8'd3,  128'hDEAD_BEEF_0000_0000_0000_0000_0000_0100, 0, 0, 1'b0, 0, 1, -1, -1, 2'b10, 1'b0};
        vt[4] = '{1'b1, 17'h10008, 8'd0,  128'h0, 0, 0, 1'b0, 0, -1, -1, -1, 2'b10, 1'b1};
        vt[5] = '{1'b0, 17'h00FF0, 8'd1,  128'h0, 0, 0, 1'b0, 0, -1, -1, -1, 2'b10, 1'b1};
        vt[6] = '{1'b0, 17'h00000, 8'd2,  128'h7700, 0, 0, 1'b0, 0, -1, 0, -1, 2'b10, 1'b0};

        aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        awready = 0; wready = 0; bresp = '0; bvalid = 0; arready = 0;
        rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset valids", {awvalid, arvalid, wvalid, bready, rready, wr_ready}, 0);
        check("reset status", {done, resp, busy, cmd_ready}, {1'b0, 2'b00, 1'b0, 1'b1});
        check("reset addr/len", {awaddr, awlen, araddr, arlen}, 0);
        aresetn = 1;

        for (int i = 0; i < 7; i++) run(vt[i], $sformatf("v%0d", i));

        // Reset pulse during W beat 10 of 50, then confirm the master recovers.
        vr = '{1'b1, 17'h10000, 8'd49, 128'h5000, 0, 0, 1'b0, 0, -1, -1, 9, 2'b00, 1'b0};
        run(vr, "midrst");
        run(vt[0], "recover");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/kyber_axi_host_master.md
Name: kyber_axi_host_master

Overview:
- AXI4 burst master that drives the Kyber accelerator's AXI4 slave port: 128-bit data, 17-bit byte address.
- Accepts one command at a time from a host-side sequencer and issues exactly one INCR burst per command:
  - Write commands load pk/sk/c/m/coin into the BRAM window (addr[16]=1) or set the start/mode registers (addr[16]=0).
  - Read commands fetch the finish register or pk/sk/c/m outputs.
- Streams write data in and read data out over valid/ready handshakes, and reports the burst response once per command.

Parameters:
- ADDR_W, 17, AXI address width in bits.
- DATA_W, 128, AXI data width in bits. Fixed; AxSIZE is 3'b100.
- LEN_W, 8, width of cmd_len and the AXI AxLEN fields.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_aresetn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command; 1 only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  17  byte start address.
- cmd_len  in  8  number of beats minus 1.
- wr_data  in  128  write beat data.
- wr_valid  in  1  write beat available.
- wr_ready  out  1  write beat consumed this cycle.
- rd_data  out  128  read beat data.
- rd_valid  out  1  read beat valid.
- rd_last  out  1  final beat of the command.
- rd_ready  in  1  sink accepts the read beat.
- done  out  1  one-cycle pulse at command completion.
- resp  out  2  completion status; valid while done=1.
- busy  out  1  state is not IDLE.
- m_axi_awaddr/awlen/awsize/awburst/awcache/awlock/awprot/awvalid  out  17/8/3/2/4/1/3/1  AXI4 write address channel.
- m_axi_awready  in  1  AXI4 write address ready.
- m_axi_wdata/wstrb/wlast/wvalid  out  128/16/1/1  AXI4 write data channel.
- m_axi_wready  in  1  AXI4 write data ready.
- m_axi_bresp/bvalid  in  2/1  AXI4 write response channel.
- m_axi_bready  out  1  AXI4 write response ready.
- m_axi_araddr/arlen/arsize/arburst/arcache/arlock/arprot/arvalid  out  17/8/3/2/4/1/3/1  AXI4 read address channel.
- m_axi_arready  in  1  AXI4 read address ready.
- m_axi_rdata/rresp/rlast/rvalid  in  128/2/1/1  AXI4 read data channel.
- m_axi_rready  out  1  AXI4 read data ready.

Behaviour:
- Constant outputs: AxSIZE=3'b100, AxBURST=2'b01, AxCACHE=4'b0011, AxLOCK=0, AxPROT=3'b000, WSTRB=16'hFFFF.
- Reset is synchronous: when m_axi_aresetn=0 at a clock edge, the FSM goes to IDLE.
- Reset values of registered outputs: all AxVALID=0, bready=0, done=0, resp=0, busy=0, address/len registers=0.
- Reset mid-burst: the burst is abandoned and no done pulse is produced. The bench holds the slave in reset alongside.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE: cmd_ready=1. On cmd_valid:
  - Check: cmd_addr[3:0]≠0, or burst crosses a 4 KB boundary (cmd_addr[11:4]+cmd_len > 255) → DONE with resp=2'b10; no AXI traffic.
  - Otherwise latch addr and len, clear the beat counter and resp accumulator, then go to AW (write) or AR (read).
  - AxVALID asserts the cycle after acceptance.
- AW: awvalid=1, held stable until awready. Handshake → W. Write data is never presented before the AW handshake.
- W: wvalid=wr_valid, wr_ready=wready, wdata=wr_data (combinational pass-through, gated by state==W).
  - wlast=1 when beat counter==len.
  - Counter increments on each wvalid&wready.
  - Last beat handshake → B.
  - Outside W, wr_ready=0.
- B: bready=1. On bvalid: resp=bresp → DONE.
- AR: arvalid=1, held stable until arready. Handshake → R.
- R: rd_valid=rvalid, rd_data=rdata, m_axi_rready=rd_ready (pass-through, gated by state==R).
  - rd_last=1 when counter==len.
  - Each handshake: resp accumulator takes max(acc, rresp), with SLVERR/DECERR dominant.
  - Final beat: if rlast≠1, acc=2'b10. Go to DONE.
  - rlast=1 before the final beat: flag 2'b10, keep counting to len.
- DONE: done=1 for exactly one cycle, resp valid, then IDLE. cmd_ready=0 in DONE, so back-to-back commands are spaced by at least 2 idle-to-valid cycles.
- Beat counter is 8-bit and saturates at len; len=0 gives a single beat with wlast/rd_last=1.
- A single outstanding transaction only; the AR and AW channels are never active together.

Test Plan:
- Write cmd addr=0x00002*16=0x00020, len=0, data=128'h3 (mode reg), awready delayed 3 cycles → awvalid held stable 4 cycles; one W beat with wlast=1; bresp=0 → done with resp=0; busy low after.
- Write burst addr=0x10000, len=49 (pk_in, 50 beats), wr_valid toggling 1/0, wready low every 3rd cycle → exactly 50 W handshakes in order; wlast only on beat 50; awlen=49.
- Read burst addr=0x10E40 (m_out, word 228), len=1, rd_ready held low 5 cycles on beat 1 → rready=0 while stalled; both beats delivered intact; rd_last on beat 2; resp=0.
- Read len=3, rresp=2'b10 on beat 2 only → all 4 beats still delivered; done resp=2'b10.
- cmd_addr=0x10008 (misaligned), and cmd_addr=0x00FF0 with len=1 (crosses 4 KB) → no AxVALID; done within 2 cycles with resp=2'b10.
- m_axi_aresetn=0 for 1 cycle during W beat 10 of 50 → next cycle all valids=0, state IDLE, cmd_ready=1, no done pulse.
